// File: rtl/alu_pipe_if.sv
// Handshake and operand/result bundle for alu_pipe: the producer drives
// the request side and the consumer ready, the ALU drives everything else.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, op, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, op, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, carry_out, overflow, zero
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage N-bit ALU (AND/OR/ADD/SUB/SLT) with a group carry-lookahead adder.
// Optional: define ALU_SAT_EN to saturate ADD/SUB on signed overflow.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int TAG_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  logic             in_ready_s;
  logic             s2_ld_s;
  logic [WIDTH-1:0] bb_s;
  logic [NG-1:0]    g_s;
  logic [NG-1:0]    p_s;
  logic [WIDTH-1:0] sum0_s;
  logic [WIDTH-1:0] sum1_s;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_bb_r;
  logic             s1_cin_r;
  logic [1:0]       s1_op_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic [NG-1:0]    s1_g_r;
  logic [NG-1:0]    s1_p_r;
  logic [WIDTH-1:0] s1_sum0_r;
  logic [WIDTH-1:0] s1_sum1_r;

  logic [NG:0]      c_s;
  logic             acc_s;
  logic             pp_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             set_s;
  logic [WIDTH-1:0] res_s;
  logic             zero_s;

  logic             s2_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [TAG_W-1:0] tag_r;
  logic             carry_r;
  logic             ovf_r;
  logic             zero_r;

  // A full pipeline can still accept when the consumer drains this cycle
  assign in_ready_s = !s1_valid_r || !s2_valid_r || bus.out_ready;
  assign s2_ld_s    = !s2_valid_r || bus.out_ready;

  // Stage 1: per-group generate/propagate and both speculative group sums
  always_comb begin
    bb_s   = bus.op[2] ? ~bus.b : bus.b;
    g_s    = '0;
    p_s    = '0;
    sum0_s = '0;
    sum1_s = '0;
    for (int i = 0; i < NG; i++) begin
      {g_s[i], sum0_s[i*GROUP +: GROUP]} = {1'b0, bus.a[i*GROUP +: GROUP]}
                                         + {1'b0, bb_s[i*GROUP +: GROUP]};
      sum1_s[i*GROUP +: GROUP] = bus.a[i*GROUP +: GROUP] + bb_s[i*GROUP +: GROUP]
                               + {{(GROUP-1){1'b0}}, 1'b1};
      p_s[i] = &(bus.a[i*GROUP +: GROUP] ^ bb_s[i*GROUP +: GROUP]);
    end
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_bb_r    <= '0;
      s1_cin_r   <= 1'b0;
      s1_op_r    <= 2'b00;
      s1_tag_r   <= '0;
      s1_g_r     <= '0;
      s1_p_r     <= '0;
      s1_sum0_r  <= '0;
      s1_sum1_r  <= '0;
    end else if (in_ready_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_r    <= bus.a;
        s1_bb_r   <= bb_s;
        s1_cin_r  <= bus.op[2];
        s1_op_r   <= bus.op[1:0];
        s1_tag_r  <= bus.in_tag;
        s1_g_r    <= g_s;
        s1_p_r    <= p_s;
        s1_sum0_r <= sum0_s;
        s1_sum1_r <= sum1_s;
      end
    end
  end

  // Stage 2: flat lookahead, each group carry is a direct OR of G/P products
  always_comb begin
    c_s    = '0;
    acc_s  = 1'b0;
    pp_s   = 1'b0;
    c_s[0] = s1_cin_r;
    for (int i = 0; i < NG; i++) begin
      acc_s = s1_g_r[i];
      pp_s  = s1_p_r[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc_s = acc_s | (pp_s & s1_g_r[j]);
        pp_s  = pp_s & s1_p_r[j];
      end
      c_s[i+1] = acc_s | (pp_s & s1_cin_r);
    end
  end

  // Stage 2: group sum select, flags and final op mux
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NG; i++) begin
      sum_s[i*GROUP +: GROUP] = c_s[i] ? s1_sum1_r[i*GROUP +: GROUP]
                                       : s1_sum0_r[i*GROUP +: GROUP];
    end
    ovf_s = (s1_a_r[MSB] == s1_bb_r[MSB]) && (sum_s[MSB] != s1_a_r[MSB]);
    set_s = sum_s[MSB] ^ ovf_s;
    case (s1_op_r)
      2'b00: res_s = s1_a_r & s1_bb_r;
      2'b01: res_s = s1_a_r | s1_bb_r;
      2'b10: begin
`ifdef ALU_SAT_EN
        // Overflow direction follows the operand sign (both operands agree)
        if (ovf_s) begin
          res_s = s1_a_r[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end else begin
          res_s = sum_s;
        end
`else
        res_s = sum_s;
`endif
      end
      2'b11:   res_s = {{MSB{1'b0}}, set_s};
      default: res_s = '0;
    endcase
    zero_s = (res_s == {WIDTH{1'b0}});
  end

  // Stage 2 register: data moves only when stage 1 holds a real operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= '0;
      tag_r      <= '0;
      carry_r    <= 1'b0;
      ovf_r      <= 1'b0;
      zero_r     <= 1'b0;
    end else if (s2_ld_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= res_s;
        tag_r    <= s1_tag_r;
        carry_r  <= c_s[NG];
        ovf_r    <= ovf_s;
        zero_r   <= zero_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.result    = result_r;
  assign bus.out_tag   = tag_r;
  assign bus.carry_out = carry_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results are queued on acceptance
// and compared when the output handshake fires.
module tb_alu_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        co;
    logic        ovf;
    logic        z;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_pipe #(.WIDTH(WIDTH), .GROUP(4), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [3:0] tag);
    logic [31:0] bb;
    logic [32:0] s;
    logic        ov;
    exp_t        e;
    bb = op[2] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {32'd0, op[2]};
    ov = (a[31] == bb[31]) && (s[31] != a[31]);
    case (op[1:0])
      2'b00: e.res = a & bb;
      2'b01: e.res = a | bb;
      2'b10: begin
        e.res = s[31:0];
`ifdef ALU_SAT_EN
        if (ov) e.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      end
      default: begin
        if (op[2]) e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else       e.res = {31'd0, s[31] ^ ov};
      end
    endcase
    e.tag = tag;
    e.co  = s[32];
    e.ovf = ov;
    e.z   = (e.res == 32'd0);
    return e;
  endfunction

  // Advance one cycle: sample outputs on the falling edge, queue accepted ops
  task automatic tick(output logic fired, output exp_t obs);
    @(negedge clk);
    fired = bus.out_valid && bus.out_ready;
    obs   = {bus.result, bus.out_tag, bus.carry_out, bus.overflow, bus.zero};
    if (rst_n && bus.in_valid && bus.in_ready)
      sb.push_back(model(bus.a, bus.b, bus.op, bus.in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic f;
    exp_t o, e;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = 32'd0; bus.b = 32'd0; bus.op = 3'd0; bus.in_tag = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.a = 32'd2; bus.b = 32'd3; bus.op = 3'b010; bus.in_tag = 4'd5;
    tick(f, o);
    bus.in_valid = 1'b0;
    tick(f, o);
    n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL latency_early: out fired %b want 0", f); end
    tick(f, o);
    n_cmp++;
    if (f !== 1'b1 || sb.size() == 0) begin
      n_err++; $display("FAIL latency_2: out fired %b want 1", f);
    end else begin
      e = sb.pop_front();
      if (o !== e || o.res !== 32'd5 || o.tag !== 4'd5) begin
        n_err++; $display("FAIL first_op: got %h want %h", o, e);
      end
    end
    sb.delete();
  endtask

  task automatic test_directed();
    vec_t v[8];
    logic f;
    exp_t o, e;
    v[0] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 3'b100, '{32'hF0F0F0F0, 4'd0, 1'b1, 1'b0, 1'b0}};
    v[1] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 3'b001, '{32'hFFFFFFFF, 4'd1, 1'b0, 1'b0, 1'b0}};
    v[2] = '{32'hFFFFFFFF, 32'h00000001, 3'b010, '{32'h00000000, 4'd2, 1'b1, 1'b0, 1'b1}};
`ifdef ALU_SAT_EN
    v[3] = '{32'h7FFFFFFF, 32'h00000001, 3'b010, '{32'h7FFFFFFF, 4'd3, 1'b0, 1'b1, 1'b0}};
    v[7] = '{32'h80000000, 32'h00000001, 3'b110, '{32'h80000000, 4'd7, 1'b1, 1'b1, 1'b0}};
`else
    v[3] = '{32'h7FFFFFFF, 32'h00000001, 3'b010, '{32'h80000000, 4'd3, 1'b0, 1'b1, 1'b0}};
    v[7] = '{32'h80000000, 32'h00000001, 3'b110, '{32'h7FFFFFFF, 4'd7, 1'b1, 1'b1, 1'b0}};
`endif
    v[4] = '{32'h00000005, 32'h00000007, 3'b110, '{32'hFFFFFFFE, 4'd4, 1'b0, 1'b0, 1'b0}};
    v[5] = '{32'h80000000, 32'h00000001, 3'b111, '{32'h00000001, 4'd5, 1'b1, 1'b1, 1'b0}};
    v[6] = '{32'h00000003, 32'h00000003, 3'b111, '{32'h00000000, 4'd6, 1'b1, 1'b0, 1'b1}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.a = v[i].a; bus.b = v[i].b; bus.op = v[i].op;
      bus.in_tag = 4'(i);
      tick(f, o);
      bus.in_valid = 1'b0;
      tick(f, o);
      tick(f, o);
      n_cmp++;
      if (f !== 1'b1 || sb.size() == 0) begin
        n_err++; $display("FAIL directed_%0d_valid: out fired %b want 1", i, f);
      end else begin
        e = sb.pop_front();
        if (o !== v[i].e) begin n_err++; $display("FAIL directed_%0d: got %h want %h", i, o, v[i].e); end
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL directed_%0d_model: got %h want %h", i, o, e); end
      end
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    logic f, saw_full, have_snap;
    exp_t o, e, snap;
    int   sent, got, n0;
    sent = 0; got = 0; saw_full = 1'b0; have_snap = 1'b0; snap = '0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      bus.in_valid  = (sent < 4);
      bus.a         = $urandom; bus.b = $urandom; bus.op = 3'($urandom_range(0, 7));
      bus.in_tag    = 4'(sent);
      bus.out_ready = !(c >= 3 && c <= 5);
      #1;
      if (!bus.in_ready) saw_full = 1'b1;
      if (bus.out_valid && !bus.out_ready) begin
        if (have_snap) begin
          n_cmp++;
          if ({bus.result, bus.out_tag, bus.carry_out, bus.overflow, bus.zero} !== snap) begin
            n_err++; $display("FAIL hold_stable: got %h want %h",
              {bus.result, bus.out_tag, bus.carry_out, bus.overflow, bus.zero}, snap);
          end
        end else begin
          snap = {bus.result, bus.out_tag, bus.carry_out, bus.overflow, bus.zero};
          have_snap = 1'b1;
        end
      end else begin
        have_snap = 1'b0;
      end
      n0 = sb.size();
      tick(f, o);
      if (sb.size() > n0) sent++;
      if (f) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL bp_extra: unexpected result %h", o);
        end else begin
          e = sb.pop_front();
          if (o !== e || o.tag !== 4'(got)) begin
            n_err++; $display("FAIL bp_order_%0d: got %h want %h", got, o, e);
          end
        end
        got++;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_cmp++; if (saw_full !== 1'b1) begin n_err++; $display("FAIL bp_in_ready: low seen %b want 1", saw_full); end
    n_cmp++; if (got != 4 || sb.size() != 0) begin n_err++; $display("FAIL bp_count: got %0d want 4 left %0d", got, sb.size()); end
    sb.delete();
  endtask

  task automatic test_random(input int cycles);
    logic        f;
    exp_t        o, e;
    logic [31:0] edge_v[4];
    logic [3:0]  tag;
    edge_v[0] = 32'h0000_0000; edge_v[1] = 32'hFFFF_FFFF;
    edge_v[2] = 32'h7FFF_FFFF; edge_v[3] = 32'h8000_0000;
    tag = 4'd0;
    for (int c = 0; c < cycles; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.a  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      bus.b  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      bus.op = 3'($urandom_range(0, 7));
      bus.in_tag = tag;
      tag = tag + 4'd1;
      tick(f, o);
      if (f) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rand_extra: unexpected result %h", o);
        end else begin
          e = sb.pop_front();
          if (o !== e) begin n_err++; $display("FAIL rand_cmp: got %h want %h", o, e); end
        end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      tick(f, o);
      if (f) begin
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL rand_drain: got %h want %h", o, e); end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL rand_timeout: %0d results missing want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_midstream();
    logic f;
    exp_t o, e;
    int   fires;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = 1'b1; bus.out_ready = ($urandom_range(0, 1) != 0);
      bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom_range(0, 7));
      bus.in_tag = 4'(c);
      tick(f, o);
      if (f && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL mid_pre: got %h want %h", o, e); end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", bus.in_ready); end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.a = 32'h0000_1234; bus.b = 32'h0000_4321; bus.op = 3'b110;
    bus.in_tag = 4'd9;
    tick(f, o);
    bus.in_valid = 1'b0;
    fires = 0;
    for (int c = 0; c < 6; c++) begin
      tick(f, o);
      if (f) begin
        fires++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL mid_extra: stale result %h", o);
        end else begin
          e = sb.pop_front();
          if (o !== e || o.res !== 32'hFFFF_CF13 || o.tag !== 4'd9) begin
            n_err++; $display("FAIL mid_post: got %h want %h", o, e);
          end
        end
      end
    end
    n_cmp++; if (fires != 1) begin n_err++; $display("FAIL mid_count: got %0d results want 1", fires); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random(300);
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
